// File: rtl/tone_gen_mc.sv
// tone_gen_mc -- multi-channel square-wave tone generator with stereo mixer.
//
// Each channel divides clk by a programmable half-period and emits a two-level
// signed sample (volume_min / volume_max). A channel whose divider is zero is
// idle and contributes 0. A note change on a running channel is held until the
// current half-period ends, so the waveform never shows a shortened pulse.
// The enabled samples are summed per side and registered.
//
// Build option:
//   TONE_GEN_SAT_EN  defined   -> mix sums saturate to the AW-bit signed range
//                    undefined -> mix sums wrap (keep the low AW bits)
//
// Parameters:
//   CH     number of tone channels (1..8)
//   DIV_W  width of each half-period divider value
//   AW     audio sample width (signed two's complement)
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   note_div      per-channel half-period in clk cycles, channel i at [i*DIV_W +: DIV_W]
//   note_load     per-channel one-cycle strobe capturing the matching note_div slice
//   note_pending  per-channel flag: a captured note waits for the next boundary
//   volume_min    per-channel low-level sample, channel i at [i*AW +: AW]
//   volume_max    per-channel high-level sample, channel i at [i*AW +: AW]
//   ch_left_en    channel i contributes to the left mix
//   ch_right_en   channel i contributes to the right mix
//   audio_left    registered left mix
//   audio_right   registered right mix

module tone_gen_mc #(
  parameter int CH    = 2,
  parameter int DIV_W = 22,
  parameter int AW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH*DIV_W-1:0] note_div,
  input  logic [CH-1:0]       note_load,
  output logic [CH-1:0]       note_pending,
  input  logic [CH*AW-1:0]    volume_min,
  input  logic [CH*AW-1:0]    volume_max,
  input  logic [CH-1:0]       ch_left_en,
  input  logic [CH-1:0]       ch_right_en,
  output logic [AW-1:0]       audio_left,
  output logic [AW-1:0]       audio_right
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

`ifdef TONE_GEN_SAT_EN
  // Three guard bits hold the sum of up to eight full-scale channels.
  localparam int SUM_W = AW + 3;
`else
  // The low AW bits of a wider sum equal the AW-bit sum itself, so in wrap
  // mode the guard bits would never be looked at and are not built.
  localparam int SUM_W = AW;
`endif

  // Per-channel samples, flattened the same way as the volume ports.
  logic [CH*AW-1:0] sample_flat;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [DIV_W-1:0] cur_div_reg;
      logic [DIV_W-1:0] cnt_reg;
      logic [DIV_W-1:0] pend_div_reg;
      logic             level_reg;
      logic             pend_reg;

      logic [DIV_W-1:0] load_div;
      logic             idle;
      logic             at_boundary;
      logic [DIV_W-1:0] div_next;

      assign load_div    = note_div[gi*DIV_W +: DIV_W];
      assign idle        = (cur_div_reg == '0);
      assign at_boundary = !idle && (cnt_reg == cur_div_reg - DIV_ONE);

      // Divider used for the next half-period: a load arriving on the
      // boundary cycle wins over anything already pending.
      assign div_next = note_load[gi] ? load_div :
                        (pend_reg ? pend_div_reg : cur_div_reg);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cur_div_reg  <= '0;
          cnt_reg      <= '0;
          pend_div_reg <= '0;
          level_reg    <= 1'b0;
          pend_reg     <= 1'b0;
        end else if (idle) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          pend_reg  <= 1'b0;
          if (note_load[gi]) begin
            cur_div_reg <= load_div;
          end
        end else if (at_boundary) begin
          cnt_reg     <= '0;
          cur_div_reg <= div_next;
          pend_reg    <= 1'b0;
          // Stopping the channel parks the level low instead of toggling.
          level_reg   <= (div_next == '0) ? 1'b0 : ~level_reg;
        end else begin
          cnt_reg <= cnt_reg + DIV_ONE;
          if (note_load[gi]) begin
            pend_div_reg <= load_div;
            pend_reg     <= 1'b1;
          end
        end
      end

      assign note_pending[gi] = pend_reg;
      assign sample_flat[gi*AW +: AW] = idle ? '0 :
          (level_reg ? volume_max[gi*AW +: AW] : volume_min[gi*AW +: AW]);
    end
  endgenerate

  logic [SUM_W-1:0] sum_left;
  logic [SUM_W-1:0] sum_right;

  // Sign-extend each sample; two's complement addition then needs no casts.
  always_comb begin
    sum_left  = '0;
    sum_right = '0;
    for (int i = 0; i < CH; i++) begin
      if (ch_left_en[i]) begin
        sum_left = sum_left +
                   {{(SUM_W-AW){sample_flat[i*AW+AW-1]}}, sample_flat[i*AW +: AW]};
      end
      if (ch_right_en[i]) begin
        sum_right = sum_right +
                    {{(SUM_W-AW){sample_flat[i*AW+AW-1]}}, sample_flat[i*AW +: AW]};
      end
    end
  end

  function automatic logic [AW-1:0] reduce_mix(input logic [SUM_W-1:0] s);
`ifdef TONE_GEN_SAT_EN
    // In range when the guard bits all copy the AW-bit sign bit.
    if ((s[SUM_W-1:AW-1] == '0) || (s[SUM_W-1:AW-1] == '1)) begin
      return s[AW-1:0];
    end else if (s[SUM_W-1]) begin
      return {1'b1, {(AW-1){1'b0}}};
    end else begin
      return {1'b0, {(AW-1){1'b1}}};
    end
`else
    return s;
`endif
  endfunction

  logic [AW-1:0] audio_left_reg;
  logic [AW-1:0] audio_right_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      audio_left_reg  <= '0;
      audio_right_reg <= '0;
    end else begin
      audio_left_reg  <= reduce_mix(sum_left);
      audio_right_reg <= reduce_mix(sum_right);
    end
  end

  assign audio_left  = audio_left_reg;
  assign audio_right = audio_right_reg;

endmodule

// File: tb/tb_tone_gen_mc.sv
module tb_tone_gen_mc;

  localparam int CH    = 2;
  localparam int DIV_W = 22;
  localparam int AW    = 16;

  logic                clk;
  logic                reset;
  logic [CH*DIV_W-1:0] note_div;
  logic [CH-1:0]       note_load;
  logic [CH-1:0]       note_pending;
  logic [CH*AW-1:0]    volume_min;
  logic [CH*AW-1:0]    volume_max;
  logic [CH-1:0]       ch_left_en;
  logic [CH-1:0]       ch_right_en;
  logic [AW-1:0]       audio_left;
  logic [AW-1:0]       audio_right;

  int errors = 0;
  int checks = 0;

  tone_gen_mc #(.CH(CH), .DIV_W(DIV_W), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .note_div     (note_div),
    .note_load    (note_load),
    .note_pending (note_pending),
    .volume_min   (volume_min),
    .volume_max   (volume_max),
    .ch_left_en   (ch_left_en),
    .ch_right_en  (ch_right_en),
    .audio_left   (audio_left),
    .audio_right  (audio_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs and samples are handled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    note_div    = '0;
    note_load   = '0;
    volume_min  = '0;
    volume_max  = '0;
    ch_left_en  = '0;
    ch_right_en = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    note_div    = '0;
    note_load   = '0;
    volume_min  = '0;
    volume_max  = '0;
    ch_left_en  = '0;
    ch_right_en = '0;
    tick();
    tick();
    checks++;
    if ({audio_left, audio_right, note_pending} !== '0) begin
      errors++;
      $display("FAIL reset_state: L=%h R=%h pend=%b, want all 0", audio_left, audio_right, note_pending);
    end
    $display("reset_state: L=%h R=%h pend=%b", audio_left, audio_right, note_pending);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_idle();
    int bad = 0;
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      tick();
      checks++;
      if (audio_left !== '0 || audio_right !== '0 || note_pending !== '0) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL idle cyc%0d: L=%h R=%h pend=%b, want 0/0/0", k, audio_left, audio_right, note_pending);
      end
    end
    $display("idle: 1000 cycles, %0d bad", bad);
  endtask

  task automatic test_single_tone();
    logic [AW-1:0] exp_l;
    do_reset();
    volume_min[0 +: AW] = 16'hFF9C;  // -100
    volume_max[0 +: AW] = 16'h0064;  // 100
    ch_left_en = 2'b01;
    note_div[0 +: DIV_W] = 22'd4;
    note_load = 2'b01;
    tick();                           // load edge E0
    note_load = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      // level after edge j is (j/4)%2; output lags by one edge
      exp_l = (((k - 1) / 4) % 2 == 1) ? 16'h0064 : 16'hFF9C;
      checks++;
      if (audio_left !== exp_l || audio_right !== '0) begin
        errors++;
        $display("FAIL single_tone E%0d: L=%h R=%h, want L=%h R=0000", k, audio_left, audio_right, exp_l);
      end
      $display("single_tone E%0d: L=%h R=%h", k, audio_left, audio_right);
    end
  endtask

  task automatic test_pending_load();
    logic [AW-1:0] exp_l;
    logic          lvl;
    logic          exp_p;
    int            j;
    do_reset();
    volume_min[0 +: AW] = 16'hFF9C;
    volume_max[0 +: AW] = 16'h0064;
    ch_left_en = 2'b01;
    note_div[0 +: DIV_W] = 22'd10;
    note_load = 2'b01;
    tick();                           // E0: idle load, cnt=0
    note_load = '0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin               // sampled while cnt==2
        note_div[0 +: DIV_W] = 22'd3;
        note_load = 2'b01;
      end
      tick();
      note_load = '0;
      j = k - 1;
      lvl = (j < 10) ? 1'b0 : ((((j - 10) / 3) % 2) == 0);
      exp_l = lvl ? 16'h0064 : 16'hFF9C;
      exp_p = (k >= 3 && k <= 9);
      checks++;
      if (audio_left !== exp_l || note_pending[0] !== exp_p) begin
        errors++;
        $display("FAIL pending_load E%0d: L=%h pend=%b, want L=%h pend=%b", k, audio_left, note_pending[0], exp_l, exp_p);
      end
      $display("pending_load E%0d: L=%h pend=%b", k, audio_left, note_pending[0]);
    end
  endtask

  task automatic test_bypass_and_stop();
    logic [AW-1:0] exp_l;
    logic          exp_p;
    int            j;
    do_reset();
    volume_min[0 +: AW] = 16'hFF9C;
    volume_max[0 +: AW] = 16'h0064;
    ch_left_en = 2'b01;
    note_div[0 +: DIV_W] = 22'd4;
    note_load = 2'b01;
    tick();                           // E0
    note_load = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) begin               // cnt==3: boundary cycle, applies at once
        note_div[0 +: DIV_W] = 22'd6;
        note_load = 2'b01;
      end
      if (k == 12) begin              // mid half-period: stop request
        note_div[0 +: DIV_W] = 22'd0;
        note_load = 2'b01;
      end
      tick();
      note_load = '0;
      j = k - 1;
      if (j < 4)       exp_l = 16'hFF9C;
      else if (j < 10) exp_l = 16'h0064;
      else if (j < 16) exp_l = 16'hFF9C;
      else             exp_l = 16'h0000;
      exp_p = (k >= 12 && k <= 15);
      checks++;
      if (audio_left !== exp_l || note_pending[0] !== exp_p) begin
        errors++;
        $display("FAIL bypass_stop E%0d: L=%h pend=%b, want L=%h pend=%b", k, audio_left, note_pending[0], exp_l, exp_p);
      end
      $display("bypass_stop E%0d: L=%h pend=%b", k, audio_left, note_pending[0]);
    end
  endtask

  task automatic test_saturation();
    logic [AW-1:0] exp_hi;
    logic [AW-1:0] exp_lo;
    logic [AW-1:0] exp_l;
`ifdef TONE_GEN_SAT_EN
    exp_hi = 16'h7FFF;
    exp_lo = 16'h8000;
`else
    exp_hi = 16'hE000;
    exp_lo = 16'h2000;                // -0xE000 wrapped
`endif
    do_reset();
    volume_max = {16'h7000, 16'h7000};
    volume_min = {16'h9000, 16'h9000};
    ch_left_en = 2'b11;
    note_div = {22'd4, 22'd4};
    note_load = 2'b11;
    tick();
    note_load = '0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_l = ((((k - 1) / 4) % 2) == 1) ? exp_hi : exp_lo;
      checks++;
      if (audio_left !== exp_l || audio_right !== '0) begin
        errors++;
        $display("FAIL saturation E%0d: L=%h R=%h, want L=%h R=0000", k, audio_left, audio_right, exp_l);
      end
      $display("saturation E%0d: L=%h R=%h", k, audio_left, audio_right);
    end
  endtask

  task automatic test_two_channel_mix();
    int            s0;
    int            s1;
    int            j;
    logic [AW-1:0] exp_l;
    logic [AW-1:0] exp_r;
    do_reset();
    volume_min = {16'h0014, 16'hFFFB};   // ch1 20, ch0 -5
    volume_max = {16'hFFE2, 16'h0007};   // ch1 -30, ch0 7
    ch_left_en  = 2'b11;
    ch_right_en = 2'b10;
    note_div = {22'd3, 22'd2};
    note_load = 2'b11;
    tick();
    note_load = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      j = k - 1;
      s0 = (((j / 2) % 2) == 1) ? 7 : -5;
      s1 = (((j / 3) % 2) == 1) ? -30 : 20;
      exp_l = AW'(s0 + s1);
      exp_r = AW'(s1);
      checks++;
      if (audio_left !== exp_l || audio_right !== exp_r) begin
        errors++;
        $display("FAIL mix E%0d: L=%h R=%h, want L=%h R=%h", k, audio_left, audio_right, exp_l, exp_r);
      end
      $display("mix E%0d: L=%h R=%h", k, audio_left, audio_right);
    end
  endtask

  task automatic test_reset_mid_tone();
    do_reset();
    volume_min[0 +: AW] = 16'hFF9C;
    volume_max[0 +: AW] = 16'h0064;
    ch_left_en  = 2'b01;
    ch_right_en = 2'b01;
    note_div[0 +: DIV_W] = 22'd10;
    note_load = 2'b01;
    tick();                           // E0
    note_load = '0;
    tick();
    tick();
    note_div[0 +: DIV_W] = 22'd3;
    note_load = 2'b01;
    tick();                           // E3: pending captured
    note_load = '0;
    tick();                           // E4
    checks++;
    if (audio_left !== 16'hFF9C || note_pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: L=%h pend=%b, want L=ff9c pend=1", audio_left, note_pending[0]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (audio_left !== '0 || audio_right !== '0 || note_pending !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: L=%h R=%h pend=%b, want 0/0/0", audio_left, audio_right, note_pending);
    end
    $display("reset_mid_async: L=%h R=%h pend=%b", audio_left, audio_right, note_pending);
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if (audio_left !== '0 || audio_right !== '0 || note_pending !== '0) begin
        errors++;
        $display("FAIL reset_mid_after cyc%0d: L=%h R=%h pend=%b, want 0/0/0", k, audio_left, audio_right, note_pending);
      end
    end
    $display("reset_mid_after: 30 cycles idle checked");
  endtask

  initial begin
    reset       = 1'b0;
    note_div    = '0;
    note_load   = '0;
    volume_min  = '0;
    volume_max  = '0;
    ch_left_en  = '0;
    ch_right_en = '0;
    test_reset();
    test_idle();
    test_single_tone();
    test_pending_load();
    test_bypass_and_stop();
    test_saturation();
    test_two_channel_mix();
    test_reset_mid_tone();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
